// File: rtl/sata_cont_inserter_ext.sv
// Transmit-side CONT inserter: repeats of one primitive beyond MIN_REPEAT become
// CONT followed by scrambled (or zero) filler; ALIGN passes without breaking the run.
`ifndef SATA_CONT_PRIMS
`define SATA_CONT_PRIMS
`define ALIGN_PRIM      32'h7B4A_4ABC
`define CONT_PRIM       32'h9999_AA7C
`define HOLD_PRIM       32'hD5D5_AA7C
`define SYNC_PRIM       32'hB5B5_957C
`define R_OK_PRIM       32'h3535_B57C
`define LFSR_POLYNOMIAL 16'hA011
`define LFSR_INITVALUE  48'h0000_0000_FFFF
`endif

module sata_cont_inserter_ext #(
    parameter int MIN_REPEAT = 2,
    parameter int FILL_MODE  = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [31:0]          i_data,
    input  logic                 i_datak,
    output logic                 i_ready,
    output logic [31:0]          o_data,
    output logic                 o_datak,
    input  logic                 o_ready,
    output logic                 cont_active,
    output logic [CNT_WIDTH-1:0] cont_cnt
);
    typedef enum logic [1:0] {ST_PASS, ST_CONT, ST_FILL} state_t;

    localparam logic [4:0] RUN_PASS_MAX = 5'(MIN_REPEAT);
    localparam logic [4:0] RUN_CONT     = 5'(MIN_REPEAT + 1);
    localparam logic [4:0] RUN_MAX      = 5'(MIN_REPEAT + 2);

    state_t                r_state;
    logic [31:0]           r_data;
    logic                  r_datak;
    logic [31:0]           r_last_prim;
    logic                  r_last_valid;
    logic [4:0]            r_run;
    logic [47:0]           r_lfsr;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic [4:0]            w_run_inc;
    logic [31:0]           w_filler;
    logic                  w_is_align;
    logic                  w_is_repeat;

    // 32 serial steps per beat; the new bit enters at the LSB end
    function automatic logic [47:0] lfsr_adv32(input logic [47:0] s);
        logic [47:0] r;
        r = s;
        for (int i = 0; i < 32; i++) begin
            r = {r[46:0], ^(r[15:0] & `LFSR_POLYNOMIAL)};
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) begin
            y[i] = x[31-i];
        end
        return y;
    endfunction

    always_comb begin
        w_run_inc   = (r_run == RUN_MAX) ? r_run : r_run + 5'd1;
        w_filler    = (FILL_MODE == 1) ? 32'h0 : bitrev32(r_lfsr[47:16]);
        w_is_align  = i_datak && (i_data == `ALIGN_PRIM);
        w_is_repeat = i_datak && r_last_valid && (i_data == r_last_prim);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_PASS;
            r_data       <= 32'h0;
            r_datak      <= 1'b0;
            r_last_prim  <= 32'h0;
            r_last_valid <= 1'b0;
            r_run        <= 5'd0;
            r_lfsr       <= `LFSR_INITVALUE;
            r_cnt        <= '0;
        end else if (o_ready) begin
            r_lfsr <= lfsr_adv32(r_lfsr);
            if (!enable) begin
                r_data       <= i_data;
                r_datak      <= i_datak;
                r_run        <= 5'd0;
                r_last_valid <= 1'b0;
                r_state      <= ST_PASS;
            end else if (w_is_align) begin
                r_data  <= i_data;
                r_datak <= 1'b1;
            end else if (w_is_repeat) begin
                r_run <= w_run_inc;
                if (w_run_inc <= RUN_PASS_MAX) begin
                    r_data  <= i_data;
                    r_datak <= 1'b1;
                    r_state <= ST_PASS;
                end else if (w_run_inc == RUN_CONT) begin
                    r_data  <= `CONT_PRIM;
                    r_datak <= 1'b1;
                    r_state <= ST_CONT;
                    r_cnt   <= (r_cnt == {CNT_WIDTH{1'b1}}) ? r_cnt : r_cnt + 1'b1;
                end else begin
                    r_data  <= w_filler;
                    r_datak <= 1'b0;
                    r_state <= ST_FILL;
                end
            end else begin
                r_data  <= i_data;
                r_datak <= i_datak;
                r_state <= ST_PASS;
                if (i_datak) begin
                    r_last_prim  <= i_data;
                    r_last_valid <= 1'b1;
                    r_run        <= 5'd1;
                end else begin
                    r_last_valid <= 1'b0;
                    r_run        <= 5'd0;
                end
            end
        end
    end

    assign i_ready     = o_ready;
    assign o_data      = r_data;
    assign o_datak     = r_datak;
    assign cont_active = (r_state != ST_PASS);
    assign cont_cnt    = r_cnt;
endmodule
